// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RTS   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;

  localparam int CNT_W = $clog2(RTS_CYCLES);

  if (RTS_CYCLES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("ps2_tx: illegal parameter value");
  end

  logic [2:0]            state;
  logic [8:0]            b;
  logic [3:0]            n;
  logic [CNT_W-1:0]      cnt;
  logic                  ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic [FILTER_LEN-1:0] fsr;
  logic                  fc, fc_next, fall;
  logic                  timeout;
  logic                  ps2c_low, ps2d_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
      fsr     <= '1;
      fc      <= 1'b1;
    end else begin
      ps2c_s1 <= ps2c;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= ps2d;
      ps2d_s2 <= ps2d_s1;
      fsr     <= {fsr[FILTER_LEN-2:0], ps2c_s2};
      fc      <= fc_next;
    end
  end

  // fc only moves once the whole sample window agrees, so short glitches vanish
  always_comb begin
    fc_next = fc;
    if (&fsr)
      fc_next = 1'b1;
    else if (~|fsr)
      fc_next = 1'b0;
  end

  assign fall = fc & ~fc_next;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WDG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDG_W-1:0] wdg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wdg <= '0;
    else if (state == IDLE || state == RTS || fall)
      wdg <= '0;
    else
      wdg <= wdg + WDG_W'(1);
  end

  assign timeout = (state == START || state == DATA || state == STOP || state == ACK) &&
                   !fall && (wdg == WDG_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      b            <= '0;
      n            <= '0;
      cnt          <= '0;
      ack_err      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      if (timeout) begin
        state        <= IDLE;
        ack_err      <= 1'b1;
        tx_done_tick <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (wr_ps2) begin
              b       <= {~^din, din};
              cnt     <= CNT_W'(RTS_CYCLES - 1);
              ack_err <= 1'b0;
              state   <= RTS;
            end
          end
          RTS: begin
            if (cnt == '0)
              state <= START;
            else
              cnt <= cnt - CNT_W'(1);
          end
          START: begin
            if (fall) begin
              n     <= 4'd8;
              state <= DATA;
            end
          end
          DATA: begin
            if (fall) begin
              b <= {1'b0, b[8:1]};
              if (n == 4'd0)
                state <= STOP;
              else
                n <= n - 4'd1;
            end
          end
          STOP: begin
            if (fall)
              state <= ACK;
          end
          ACK: begin
            if (fall) begin
              ack_err      <= ps2d_s2;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Drives decode straight from state so an async reset releases both lines at once
  assign ps2c_low = (state == RTS);
  assign ps2d_low = (state == RTS) || (state == START) || (state == DATA && !b[0]);

  assign ps2c    = ps2c_low ? 1'b0 : 1'bz;
  assign ps2d    = ps2d_low ? 1'b0 : 1'bz;
  assign tx_idle = (state == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;

  localparam int RTS_CYCLES     = 100;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int HALF           = 100;
  localparam int BIG            = 32'h3fff_ffff;

  logic       clk;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  logic dev_c_low, dev_d_low;
  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx #(
    .RTS_CYCLES    (RTS_CYCLES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit check_en = 0;

  // Model of the frame in progress: when it was accepted and when each device fall happened
  int         acc_cyc;
  int         fall_cyc[12];
  int         nf;
  int         done_cyc;
  logic [7:0] m_din;
  bit         frame_valid;
  bit         ack_val;
  bit         err_hold;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done_tick) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  function automatic bit model_err();
    if (!frame_valid || cyc < acc_cyc) return err_hold;
    if (cyc < done_cyc) return 1'b0;
    return ack_val;
  endfunction

  // After k device falls (each felt 2 sync + FILTER_LEN + 1 edges later) the wire shows frame bit k
  always @(negedge clk) begin
    int         k;
    logic [3:0] ki;
    bit         busy, host_d_low, e_c, e_d;
    logic [10:0] f;
    if (check_en) begin
      k = 0;
      for (int i = 0; i < nf; i++)
        if (fall_cyc[i] + FILTER_LEN + 3 <= cyc) k++;
      ki = 4'(k);
      busy = frame_valid && cyc >= acc_cyc && cyc < done_cyc;
      f = exp_frame(m_din);
      host_d_low = 1'b0;
      if (busy && k <= 10) host_d_low = !f[ki];
      e_c = !((busy && cyc < acc_cyc + RTS_CYCLES) || dev_c_low);
      e_d = !(host_d_low || dev_d_low);
      check("tx_idle", {31'd0, tx_idle}, {31'd0, !busy});
      check("tx_done_tick", {31'd0, tx_done_tick}, {31'd0, frame_valid && cyc == done_cyc});
      check("ack_err", {31'd0, ack_err}, {31'd0, model_err()});
      check("ps2c_line", {31'd0, ps2c}, {31'd0, e_c});
      check("ps2d_line", {31'd0, ps2d}, {31'd0, e_d});
    end
  end

  task automatic send(input logic [7:0] v, input bit ack, input int nclk, input bit inject,
                      output logic [10:0] got);
    got = '0;
    err_hold = model_err();
    wr_ps2 = 1'b1;
    din = v;
    acc_cyc = cyc + 1;
    m_din = v;
    nf = 0;
    done_cyc = BIG;
    ack_val = !ack;
    frame_valid = 1'b1;
    tick(1);
    wr_ps2 = 1'b0;
    check("idle_low_after_wr", {31'd0, tx_idle}, 32'd0);
    check("err_clear_on_wr", {31'd0, ack_err}, 32'd0);
    tick(RTS_CYCLES + 20);
    got[0] = ps2d;
    for (int k = 1; k <= nclk; k++) begin
      dev_c_low = 1'b1;
      fall_cyc[nf] = cyc;
      nf++;
      if (nf == 12) done_cyc = cyc + FILTER_LEN + 3;
      if (inject && k == 3) begin
        tick(30);
        wr_ps2 = 1'b1;
        din = 8'h55;
        tick(1);
        wr_ps2 = 1'b0;
        tick(HALF - 31);
      end else begin
        tick(HALF);
      end
      dev_c_low = 1'b0;
      if (k <= 10) got[k] = ps2d;
      if (k == 10 && ack) begin
        tick(HALF / 2);
        dev_d_low = 1'b1;
        tick(HALF / 2);
      end else begin
        if (k == 12) dev_d_low = 1'b0;
        tick(HALF);
      end
    end
  endtask

  initial begin
    logic [10:0] got;
    int          dc0;
    reset = 1'b0;
    wr_ps2 = 1'b0;
    din = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    frame_valid = 1'b0;
    err_hold = 1'b0;
    nf = 0;
    done_cyc = BIG;
    acc_cyc = 0;
    m_din = 8'h00;
    ack_val = 1'b0;
    tick(5);
    check_en = 1'b1;
    check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check("rst_ps2c", {31'd0, ps2c}, 32'd1);
    check("rst_ps2d", {31'd0, ps2d}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(5);

    send(8'hED, 1'b1, 12, 1'b0, got);
    check("frame_ed", {21'd0, got}, 32'h7DA);
    check("ed_ack_err", {31'd0, ack_err}, 32'd0);
    check("ed_idle", {31'd0, tx_idle}, 32'd1);

    send(8'h00, 1'b1, 12, 1'b0, got);
    check("frame_00", {21'd0, got}, 32'h600);

    send(8'h3C, 1'b0, 12, 1'b0, got);
    check("frame_3c", {21'd0, got}, 32'h678);
    check("missing_ack_err", {31'd0, ack_err}, 32'd1);

    send(8'hFF, 1'b1, 12, 1'b0, got);
    check("frame_ff", {21'd0, got}, 32'h7FE);
    check("ff_ack_err", {31'd0, ack_err}, 32'd0);

    dc0 = done_cnt;
    send(8'hF4, 1'b1, 12, 1'b1, got);
    check("frame_f4_busy_wr", {21'd0, got}, 32'h5E8);
    check("busy_one_done", done_cnt - dc0, 32'd1);

    dc0 = done_cnt;
    send(8'h92, 1'b1, 4, 1'b0, got);
    tick(20);
    check("mid_d3_low", {31'd0, ps2d}, 32'd0);
    check("mid_bits", {27'd0, got[4:0]}, 32'h04);
    reset = 1'b0;
    frame_valid = 1'b0;
    err_hold = 1'b0;
    #1;
    check("mid_rst_ps2c", {31'd0, ps2c}, 32'd1);
    check("mid_rst_ps2d", {31'd0, ps2d}, 32'd1);
    check("mid_rst_idle", {31'd0, tx_idle}, 32'd1);
    tick(5);
    reset = 1'b1;
    tick(200);
    check("mid_rst_no_done", done_cnt - dc0, 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    dc0 = done_cnt;
    err_hold = model_err();
    wr_ps2 = 1'b1;
    din = 8'hED;
    acc_cyc = cyc + 1;
    m_din = 8'hED;
    nf = 0;
    ack_val = 1'b1;
    done_cyc = acc_cyc + RTS_CYCLES + TIMEOUT_CYCLES;
    frame_valid = 1'b1;
    tick(1);
    wr_ps2 = 1'b0;
    tick(RTS_CYCLES + TIMEOUT_CYCLES + 20);
    check("wdg_ack_err", {31'd0, ack_err}, 32'd1);
    check("wdg_done", done_cnt - dc0, 32'd1);
    check("wdg_ps2d", {31'd0, ps2d}, 32'd1);
`endif

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the attached keyboard over the shared open-drain ps2c/ps2d lines. It performs the request-to-send sequence and shifts out start, data, parity and stop bits on device-generated clock edges, then samples the device acknowledge. It sits beside the keyboard scan-code receiver on the same two lines; the receiver is held off while `tx_idle` is 0.

## Interface
- `RTS_CYCLES`, 12000: number of cycles ps2c is held low for request-to-send. 12000 is 120 µs at 100 MHz. Must be ≥ 2.
- `FILTER_LEN`, 8: ps2c glitch-filter depth in samples.
- `TIMEOUT_CYCLES`, 2000000: watchdog limit in cycles (20 ms at 100 MHz). Used only with `PS2_TX_TIMEOUT_EN`.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wr_ps2` input 1: single-cycle write strobe. Accepted only when `tx_idle`=1.
- `din` input 8: command byte, captured on an accepted `wr_ps2`.
- `ps2c` inout 1: PS/2 clock. Open-drain: driven 0 or left at z, never driven 1.
- `ps2d` inout 1: PS/2 data. Open-drain, same as `ps2c`.
- `tx_idle` output 1: 1 when the FSM is in `IDLE`.
- `tx_done_tick` output 1: one-cycle pulse at the end of a frame.
- `ack_err` output 1: status flag. Set when the device does not acknowledge (or, with the macro, when the watchdog fires). Cleared on the next accepted write.

## Operation
- **Input conditioning:** ps2c and ps2d are each synchronized through 2 flops.
  - Filtered clock `fc` is set to 1 when `FILTER_LEN` consecutive samples are 1, and to 0 when `FILTER_LEN` consecutive samples are 0. Otherwise it holds.
  - `fall` = `fc`=1 and next `fc`=0 (one-cycle pulse).
- **Frame register:** `b` is 9 bits, {parity, din}. Parity is odd: `~^din`. Bit counter `n` is 4 bits.
- **States and transitions:**
  - `IDLE`: both lines released.
    - On `wr_ps2`: load `b`, set `cnt` to `RTS_CYCLES-1`, clear `ack_err`, go to `RTS`.
  - `RTS`: drive ps2c=0 and ps2d=0.
    - Decrement `cnt`; at 0 go to `START`.
  - `START`: release ps2c, keep driving ps2d=0 (this is the start bit).
    - On `fall`: set `n`=8, go to `DATA`.
  - `DATA`: ps2d is driven 0 when `b[0]`=0 and released when `b[0]`=1.
    - On `fall`: shift `b` right. If `n`=0 go to `STOP`, otherwise decrement `n`.
    - Order on the wire: d0 through d7, then parity.
  - `STOP`: release ps2d (stop bit = 1).
    - On `fall`: go to `ACK`.
  - `ACK`: lines released.
    - On `fall`: set `ack_err` = synchronized ps2d (should be 0 for a valid ack), pulse `tx_done_tick`, go to `IDLE`.
- **Boundary conditions:**
  - `wr_ps2` while not idle is ignored; `din` is not captured.
  - A `fall` during `RTS` is ignored, since the host owns the clock.
  - A glitch shorter than `FILTER_LEN` cycles produces no `fall`.
  - Reset asserted mid-frame: both lines released immediately (asynchronously), FSM returns to `IDLE`, no `tx_done_tick`.

## Timing
- **Reset values:** `tx_idle`=1, `tx_done_tick`=0, `ack_err`=0, ps2c and ps2d = z.
- `tx_idle` goes to 0 in the cycle after `wr_ps2` is accepted.
- ps2c is low for exactly `RTS_CYCLES` cycles.
- ps2d is low from the first `RTS` cycle until the first `fall` in `START`.
- Each driven data bit changes 1 cycle after `fall`. The device samples on the rising edge, so this gives a full half-period of setup.
- A `fall` appears 2 (sync) + `FILTER_LEN` cycles after the pin edge.
- `tx_done_tick` fires on the same edge as the `ACK`→`IDLE` transition. `tx_idle` goes to 1 in that same cycle.
- A new `wr_ps2` is accepted in the cycle after `tx_done_tick`.

## Configuration
- **`PS2_TX_TIMEOUT_EN` defined:**
  - A watchdog counter starts when the FSM enters `START` and resets on every `fall`.
  - If it reaches `TIMEOUT_CYCLES` in `START`, `DATA`, `STOP` or `ACK`: release both lines, set `ack_err`=1, pulse `tx_done_tick`, return to `IDLE`.
- **Undefined:** there is no counter, and with no device attached the FSM waits indefinitely in `START`.

## Test plan
All scenarios use `RTS_CYCLES`=100, `FILTER_LEN`=8, a 100 MHz clock and a device model clocking at 1 µs half-period.
- **Normal send:** `wr_ps2` with `din`=0xED → ps2c low for 100 cycles; device samples 0 (start), bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks with 0 → `tx_done_tick`=1 for one cycle, `ack_err`=0, `tx_idle`=1.
- **Parity of zero byte:** `din`=0x00 → eight 0 data bits, then parity bit 1.
- **Missing ack:** device leaves ps2d high during the ack clock → `ack_err`=1. The next write with 0xFF clears it to 0 on acceptance.
- **Busy write:** second `wr_ps2` with 0x55 during `DATA` of a 0xF4 frame → only 0xF4 appears on the wire; exactly one `tx_done_tick`.
- **Reset mid-frame:** reset asserted after 4 data bits → ps2c and ps2d go to z in the same cycle, `tx_idle`=1, no done pulse.
- **Watchdog (macro defined, `TIMEOUT_CYCLES`=500):** no device clock after `RTS` → 500 cycles after entering `START`, `ack_err`=1 and `tx_done_tick`=1, with lines released.
